// File: rtl/clk_div_pwm.sv
// Programmable clock divider / PWM: one shared period counter drives NCH duty-cycle outputs.
// Optional macro CLK_DIV_PWM_POLARITY_EN adds per-channel output inversion via cfg_pol.
module clk_div_pwm #(
  parameter int CNT_W    = 8,
  parameter int NCH      = 2,
  parameter int RST_TERM = 4,
  parameter int RST_HIGH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_W-1:0]     cfg_term,
  input  logic [NCH*CNT_W-1:0] cfg_high,
`ifdef CLK_DIV_PWM_POLARITY_EN
  input  logic [NCH-1:0]       cfg_pol,
`endif
  output logic [NCH-1:0]       clk_out,
  output logic                 tc
);

  localparam logic [CNT_W-1:0] TERM_INIT = CNT_W'(RST_TERM);
  localparam logic [CNT_W-1:0] HIGH_INIT = CNT_W'(RST_HIGH);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] term_reg;
  logic [CNT_W-1:0] shadow_term_reg;
  logic             pending_reg;
  logic             tc_reg;

  logic wrap;
  logic take_cfg;
  logic apply_cfg;

  assign wrap      = (count_reg == term_reg);
  assign take_cfg  = cfg_valid & ~pending_reg;
  // Shadow moves to active only at a period boundary, or at once while stopped.
  assign apply_cfg = pending_reg & (wrap | ~en);
  assign cfg_ready = ~pending_reg;
  assign tc        = tc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      term_reg    <= TERM_INIT;
      pending_reg <= 1'b0;
      tc_reg      <= 1'b0;
    end else begin
      tc_reg <= en & wrap;
      if (!en || wrap) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
      if (apply_cfg) begin
        term_reg    <= shadow_term_reg;
        pending_reg <= 1'b0;
      end else if (take_cfg) begin
        pending_reg <= 1'b1;
      end
    end
  end

  // Shadow contents are meaningless until pending is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (take_cfg) begin
      shadow_term_reg <= cfg_term;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CNT_W-1:0] high_reg;
      logic [CNT_W-1:0] shadow_high_reg;
      logic             out_reg;
      logic             pol;

`ifdef CLK_DIV_PWM_POLARITY_EN
      logic pol_reg;
      logic shadow_pol_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pol_reg <= 1'b0;
        end else if (apply_cfg) begin
          pol_reg <= shadow_pol_reg;
        end
      end

      always_ff @(posedge clk) begin
        if (take_cfg) begin
          shadow_pol_reg <= cfg_pol[gi];
        end
      end

      assign pol = pol_reg;
`else
      assign pol = 1'b0;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          high_reg <= HIGH_INIT;
          out_reg  <= 1'b0;
        end else begin
          // high > term keeps the compare true all period; high == 0 keeps it false.
          out_reg <= en & ((count_reg < high_reg) ^ pol);
          if (apply_cfg) begin
            high_reg <= shadow_high_reg;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (take_cfg) begin
          shadow_high_reg <= cfg_high[gi*CNT_W +: CNT_W];
        end
      end

      assign clk_out[gi] = out_reg;
    end
  endgenerate

endmodule
